// File: rtl/cache_nway_if.sv
// cache_nway_if: pipeline/controller request and response bundle for cache_nway
interface cache_nway_if #(parameter int ADDR_BITS = 32, WAYS = 4, SETS = 16, LINE_WORDS = 4);
  localparam int TAG_BITS = ADDR_BITS - $clog2(SETS) - $clog2(LINE_WORDS) - 2;
  logic [ADDR_BITS-1:0] addr;
  logic load, edit, store, evict, invalid;
  logic [2:0] u_b_h_w;
  logic [31:0] din, dout;
  logic hit, valid, dirty, busy;
  logic [$clog2(WAYS)-1:0] hit_way;
  logic [TAG_BITS-1:0] tag;
  modport master (output addr, load, edit, store, evict, invalid, u_b_h_w, din,
                  input hit, hit_way, dout, valid, dirty, tag, busy);
  modport slave (input addr, load, edit, store, evict, invalid, u_b_h_w, din,
                 output hit, hit_way, dout, valid, dirty, tag, busy);
endinterface

// File: rtl/cache_nway.sv
// cache_nway: N-way set-associative data cache with true-LRU ages, burst fill/evict and flush sweep
module cache_nway #(parameter int ADDR_BITS = 32, WAYS = 4, SETS = 16, LINE_WORDS = 4) (
  input logic clk,
  input logic rst,
  cache_nway_if.slave bus
);
  localparam int WAY_W = $clog2(WAYS);
  localparam int OFS_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_BITS = ADDR_BITS - IDX_W - OFS_W - 2;
  localparam int CNT_W = (OFS_W > IDX_W ? OFS_W : IDX_W) + 1;
  localparam logic [1:0] IDLE = 2'd0, FILL = 2'd1, EVICT = 2'd2, FLUSH = 2'd3;
  logic [1:0] state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] fidx_q, fidx_d;
  logic [WAY_W-1:0] fway_q, fway_d;
  logic [TAG_BITS-1:0] ftag_q, ftag_d;
  logic [31:0] data_q [SETS][WAYS][LINE_WORDS];
  logic [31:0] data_d [SETS][WAYS][LINE_WORDS];
  logic [TAG_BITS-1:0] tags_q [SETS][WAYS];
  logic [TAG_BITS-1:0] tags_d [SETS][WAYS];
  logic [WAYS-1:0] vld_q [SETS];
  logic [WAYS-1:0] vld_d [SETS];
  logic [WAYS-1:0] drt_q [SETS];
  logic [WAYS-1:0] drt_d [SETS];
  logic [WAY_W-1:0] age_q [SETS][WAYS];
  logic [WAY_W-1:0] age_d [SETS][WAYS];
  logic hit_q, hit_d, valid_q, valid_d, dirty_q, dirty_d, busy_q, busy_d;
  logic [WAY_W-1:0] hit_way_q, hit_way_d;
  logic [31:0] dout_q, dout_d;
  logic [TAG_BITS-1:0] tag_q, tag_d;
  logic [TAG_BITS-1:0] a_tag;
  logic [IDX_W-1:0] a_idx, t_set, m_set;
  logic [OFS_W-1:0] a_ofs;
  logic hit_any, inv_any, t_en;
  logic [WAY_W-1:0] hit_w, vic_w, tgt_w, t_way, m_way;
  logic [31:0] rd_word, ext, mask, wdata, merged;
  logic [7:0] byte_v;
  logic [15:0] half_v;
  assign a_tag = bus.addr[ADDR_BITS-1 -: TAG_BITS];
  assign a_idx = bus.addr[2+OFS_W +: IDX_W];
  assign a_ofs = bus.addr[2 +: OFS_W];
  always_comb begin
    hit_any = 1'b0;
    inv_any = 1'b0;
    hit_w = '0;
    vic_w = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (vld_q[a_idx][w] && tags_q[a_idx][w] == a_tag) begin
        hit_any = 1'b1;
        hit_w = WAY_W'(w);
      end
      if (!vld_q[a_idx][w]) begin
        inv_any = 1'b1;
        vic_w = WAY_W'(w);
      end
    end
    if (!inv_any)
      for (int w = 0; w < WAYS; w++)
        if (age_q[a_idx][w] == WAY_W'(WAYS - 1)) vic_w = WAY_W'(w);
    tgt_w = hit_any ? hit_w : vic_w;
    rd_word = data_q[a_idx][hit_w][a_ofs];
    byte_v = rd_word[{bus.addr[1:0], 3'b000} +: 8];
    half_v = rd_word[{bus.addr[1], 4'b0000} +: 16];
    ext = bus.u_b_h_w[1:0] == 2'b00 ? {{24{~bus.u_b_h_w[2] & byte_v[7]}}, byte_v} :
          bus.u_b_h_w[1:0] == 2'b01 ? {{16{~bus.u_b_h_w[2] & half_v[15]}}, half_v} : rd_word;
    mask = bus.u_b_h_w[1:0] == 2'b00 ? 32'hFF << {bus.addr[1:0], 3'b000} :
           bus.u_b_h_w[1:0] == 2'b01 ? 32'hFFFF << {bus.addr[1], 4'b0000} : '1;
    wdata = bus.u_b_h_w[1:0] == 2'b00 ? {4{bus.din[7:0]}} :
            bus.u_b_h_w[1:0] == 2'b01 ? {2{bus.din[15:0]}} : bus.din;
    merged = (rd_word & ~mask) | (wdata & mask);
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    fidx_d = fidx_q;
    fway_d = fway_q;
    ftag_d = ftag_q;
    data_d = data_q;
    tags_d = tags_q;
    vld_d = vld_q;
    drt_d = drt_q;
    age_d = age_q;
    hit_d = hit_q;
    hit_way_d = hit_way_q;
    dout_d = dout_q;
    t_en = 1'b0;
    t_set = a_idx;
    t_way = hit_w;
    case (state_q)
      IDLE: begin
        if (bus.invalid) begin
          state_d = FLUSH;
          cnt_d = '0;
        end else if (bus.store) begin
          // The target line is invalidated until its last beat lands, so an aborted fill never hits
          state_d = FILL;
          cnt_d = CNT_W'(1);
          fidx_d = a_idx;
          fway_d = tgt_w;
          ftag_d = a_tag;
          data_d[a_idx][tgt_w][0] = bus.din;
          vld_d[a_idx][tgt_w] = 1'b0;
        end else if (bus.evict) begin
          state_d = EVICT;
          cnt_d = '0;
          fidx_d = a_idx;
          fway_d = tgt_w;
        end else if (bus.load || bus.edit) begin
          hit_d = hit_any;
          hit_way_d = hit_w;
          t_en = hit_any;
          if (bus.load) dout_d = hit_any ? ext : '0;
          if (bus.edit && hit_any) begin
            data_d[a_idx][hit_w][a_ofs] = merged;
            drt_d[a_idx][hit_w] = 1'b1;
          end
        end
      end
      FILL: begin
        if (cnt_q == CNT_W'(LINE_WORDS)) begin
          state_d = IDLE;
          vld_d[fidx_q][fway_q] = 1'b1;
          drt_d[fidx_q][fway_q] = 1'b0;
          tags_d[fidx_q][fway_q] = ftag_q;
          t_en = 1'b1;
          t_set = fidx_q;
          t_way = fway_q;
        end else if (bus.store) begin
          data_d[fidx_q][fway_q][cnt_q[OFS_W-1:0]] = bus.din;
          cnt_d = cnt_q + 1'b1;
        end
      end
      EVICT: begin
        dout_d = data_q[fidx_q][fway_q][cnt_q[OFS_W-1:0]];
        cnt_d = cnt_q + 1'b1;
        state_d = cnt_q == CNT_W'(LINE_WORDS - 1) ? IDLE : EVICT;
      end
      default: begin
        vld_d[cnt_q[IDX_W-1:0]] = '0;
        drt_d[cnt_q[IDX_W-1:0]] = '0;
        for (int w = 0; w < WAYS; w++) age_d[cnt_q[IDX_W-1:0]][w] = WAY_W'(w);
        cnt_d = cnt_q + 1'b1;
        state_d = cnt_q == CNT_W'(SETS - 1) ? IDLE : FLUSH;
      end
    endcase
    if (t_en) begin
      for (int w = 0; w < WAYS; w++)
        if (age_q[t_set][w] < age_q[t_set][t_way]) age_d[t_set][w] = age_q[t_set][w] + 1'b1;
      age_d[t_set][t_way] = '0;
    end
    m_set = state_q == EVICT ? fidx_q : a_idx;
    m_way = state_q == EVICT ? fway_q : tgt_w;
    valid_d = vld_q[m_set][m_way];
    dirty_d = drt_q[m_set][m_way];
    tag_d = tags_q[m_set][m_way];
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      fidx_q <= '0;
      fway_q <= '0;
      ftag_q <= '0;
      hit_q <= 1'b0;
      hit_way_q <= '0;
      dout_q <= '0;
      valid_q <= 1'b0;
      dirty_q <= 1'b0;
      tag_q <= '0;
      busy_q <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        vld_q[s] <= '0;
        drt_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) age_q[s][w] <= WAY_W'(w);
      end
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      fidx_q <= fidx_d;
      fway_q <= fway_d;
      ftag_q <= ftag_d;
      hit_q <= hit_d;
      hit_way_q <= hit_way_d;
      dout_q <= dout_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
      tag_q <= tag_d;
      busy_q <= busy_d;
      vld_q <= vld_d;
      drt_q <= drt_d;
      age_q <= age_d;
    end
  end
  always_ff @(posedge clk) begin
    data_q <= data_d;
    tags_q <= tags_d;
  end
  assign bus.hit = hit_q;
  assign bus.hit_way = hit_way_q;
  assign bus.dout = dout_q;
  assign bus.valid = valid_q;
  assign bus.dirty = dirty_q;
  assign bus.tag = tag_q;
  assign bus.busy = busy_q;
endmodule

// File: tb/tb_cache_nway.sv
// tb_cache_nway: scoreboard bench for cache_nway (4 ways, 16 sets, 4-word lines)
module tb_cache_nway;
  localparam int K_HIT = 0, K_WAY = 1, K_DOUT = 2, K_VALID = 3, K_DIRTY = 4, K_TAG = 5, K_BUSY = 6;
  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;
  typedef struct {string name; int due; int kind; logic [31:0] val;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  cache_nway_if bus ();
  cache_nway dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  exp_t sb[$];
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  function automatic logic [31:0] observe(input int kind);
    case (kind)
      K_HIT: return 32'(bus.hit);
      K_WAY: return 32'(bus.hit_way);
      K_DOUT: return bus.dout;
      K_VALID: return 32'(bus.valid);
      K_DIRTY: return 32'(bus.dirty);
      K_TAG: return 32'(bus.tag);
      default: return 32'(bus.busy);
    endcase
  endfunction
  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    for (int i = sb.size() - 1; i >= 0; i--)
      if (sb[i].due <= cyc) begin
        check(sb[i].name, observe(sb[i].kind), sb[i].val);
        sb.delete(i);
      end
  end
  task automatic exp_at(input string name, input int dly, input int kind, input logic [31:0] val);
    sb.push_back('{name, cyc + dly, kind, val});
  endtask
  task automatic cycle_in(input logic [31:0] a, input logic ld, ed, st, ev, inv,
                          input logic [2:0] sz, input logic [31:0] d);
    bus.addr = a;
    bus.load = ld;
    bus.edit = ed;
    bus.store = st;
    bus.evict = ev;
    bus.invalid = inv;
    bus.u_b_h_w = sz;
    bus.din = d;
    @(negedge clk);
    bus.load = 1'b0;
    bus.edit = 1'b0;
    bus.store = 1'b0;
    bus.evict = 1'b0;
    bus.invalid = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) cycle_in(32'h0, 0, 0, 0, 0, 0, LW, 32'h0);
  endtask
  task automatic load(input logic [31:0] a, input logic [2:0] sz, input logic h, input logic [31:0] d);
    exp_at($sformatf("ld_%h_hit", a), 1, K_HIT, 32'(h));
    exp_at($sformatf("ld_%h_dout", a), 1, K_DOUT, d);
    cycle_in(a, 1, 0, 0, 0, 0, sz, 32'h0);
  endtask
  task automatic fill(input logic [31:0] a, input logic [31:0] w0, w1, w2, w3, input int gap);
    logic [31:0] w [4];
    w = '{w0, w1, w2, w3};
    for (int k = 0; k < 4; k++) begin
      if (k == gap) idle(1);
      cycle_in(a, 0, 0, 1, 0, 0, LW, w[k]);
    end
    idle(1);
  endtask
  task automatic fill_set0(input logic [31:0] a);
    fill(a, 32'hA000_0000 | a, 32'hA000_0001 | a, 32'hA000_0002 | a, 32'hA000_0003 | a, -1);
  endtask
  initial begin
    logic [31:0] ev_words [4];
    ev_words = '{32'hBEEF0011, 32'h22, 32'h80332211, 32'h44};
    bus.addr = '0;
    bus.load = 1'b0;
    bus.edit = 1'b0;
    bus.store = 1'b0;
    bus.evict = 1'b0;
    bus.invalid = 1'b0;
    bus.u_b_h_w = LW;
    bus.din = '0;
    @(negedge clk);
    for (int k = 0; k <= K_BUSY; k++) exp_at($sformatf("rst_out%0d", k), 1, k, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    exp_at("empty_valid", 1, K_VALID, 32'h0);
    exp_at("empty_busy", 1, K_BUSY, 32'h0);
    load(32'h1000, LW, 1'b0, 32'h0);
    for (int k = 1; k <= 5; k++) exp_at($sformatf("fill_busy%0d", k), k, K_BUSY, 32'h1);
    exp_at("fill_busy_end", 6, K_BUSY, 32'h0);
    fill(32'h1000, 32'h11, 32'h22, 32'h80332211, 32'h44, 2);
    load(32'h1008, LW, 1'b1, 32'h80332211);
    load(32'h100B, LB, 1'b1, 32'hFFFFFF80);
    load(32'h100B, LBU, 1'b1, 32'h00000080);
    load(32'h100A, LHU, 1'b1, 32'h00008033);
    load(32'h1002, LH, 1'b1, 32'h00000000);
    exp_at("sh_hit", 1, K_HIT, 32'h1);
    cycle_in(32'h1002, 0, 1, 0, 0, 0, LH, 32'h0000BEEF);
    exp_at("sh_dirty", 1, K_DIRTY, 32'h1);
    load(32'h1000, LW, 1'b1, 32'hBEEF0011);
    exp_at("ev_busy_start", 1, K_BUSY, 32'h1);
    exp_at("ev_busy_last", 4, K_BUSY, 32'h1);
    exp_at("ev_busy_end", 5, K_BUSY, 32'h0);
    exp_at("ev_dirty", 2, K_DIRTY, 32'h1);
    exp_at("ev_valid", 3, K_VALID, 32'h1);
    exp_at("ev_tag", 2, K_TAG, 32'h10);
    for (int k = 0; k < 4; k++) exp_at($sformatf("ev_word%0d", k), k + 2, K_DOUT, ev_words[k]);
    cycle_in(32'h1000, 0, 0, 0, 1, 0, LW, 32'h0);
    idle(4);
    exp_at("ldedit_hit", 1, K_HIT, 32'h1);
    exp_at("ldedit_dout", 1, K_DOUT, 32'h44);
    cycle_in(32'h100C, 1, 1, 0, 0, 0, LW, 32'h12345678);
    load(32'h100C, LW, 1'b1, 32'h12345678);
    exp_at("edit_miss_hit", 1, K_HIT, 32'h0);
    cycle_in(32'h2000, 0, 1, 0, 0, 0, LW, 32'hDEADDEAD);
    load(32'h1000, LW, 1'b1, 32'hBEEF0011);
    exp_at("fl_busy_start", 1, K_BUSY, 32'h1);
    exp_at("fl_busy_last", 16, K_BUSY, 32'h1);
    exp_at("fl_busy_end", 17, K_BUSY, 32'h0);
    cycle_in(32'h0, 0, 0, 0, 0, 1, LW, 32'h0);
    idle(16);
    load(32'h1000, LW, 1'b0, 32'h0);
    load(32'h100C, LW, 1'b0, 32'h0);
    exp_at("fl_dirty", 1, K_DIRTY, 32'h0);
    load(32'h1008, LW, 1'b0, 32'h0);
    fill_set0(32'h000);
    fill_set0(32'h100);
    fill_set0(32'h200);
    fill_set0(32'h300);
    exp_at("lru_touch_way", 1, K_WAY, 32'h0);
    load(32'h000, LW, 1'b1, 32'hA0000000);
    fill_set0(32'h400);
    load(32'h100, LW, 1'b0, 32'h0);
    exp_at("lru_keep_way", 1, K_WAY, 32'h0);
    load(32'h000, LW, 1'b1, 32'hA0000000);
    exp_at("lru_new_way", 1, K_WAY, 32'h1);
    load(32'h40C, LW, 1'b1, 32'hA0000403);
    exp_at("lru_w3_way", 1, K_WAY, 32'h3);
    load(32'h304, LW, 1'b1, 32'hA0000301);
    cycle_in(32'h500, 0, 0, 1, 0, 0, LW, 32'h1);
    cycle_in(32'h500, 0, 0, 1, 0, 0, LW, 32'h2);
    exp_at("abort_busy", 1, K_BUSY, 32'h0);
    exp_at("abort_hit", 1, K_HIT, 32'h0);
    bus.addr = 32'h500;
    bus.store = 1'b1;
    bus.din = 32'h3;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.store = 1'b0;
    exp_at("abort_busy_after", 1, K_BUSY, 32'h0);
    load(32'h500, LW, 1'b0, 32'h0);
    load(32'h000, LW, 1'b0, 32'h0);
    idle(2);
    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cache_nway.md
# cache_nway

Parametrised N-way set-associative data cache: the next generation of the team's 2-way cache array. It generalises ways, sets and line length, replaces the single recent bit with true LRU age counters, and adds three sequencers: a burst line fill, a burst victim read-out for write-back, and a whole-cache flush sweep. It sits between the pipeline memory stage and the cache controller FSM. The controller drives fill and evict bursts; the pipeline issues loads and stores.

## Interface
- ADDR_BITS, 32, address width
- WAYS, 4, associativity; power of 2, 2..8
- SETS, 16, number of sets; power of 2, ≥2
- LINE_WORDS, 4, 32-bit words per line; power of 2, ≥2
- Derived: OFS_W=log2(LINE_WORDS), IDX_W=log2(SETS), TAG_BITS=ADDR_BITS-IDX_W-OFS_W-2. Address fields: tag | index | word offset | byte[1:0].

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- addr  in  ADDR_BITS  access address
- load  in  1  read the addressed word; a hit updates LRU
- edit  in  1  write din into the addressed word on a hit; sets dirty
- store  in  1  fill beat; the first beat in IDLE starts a line fill
- evict  in  1  start a victim read-out burst for the set of addr
- invalid  in  1  start a flush sweep of all sets
- u_b_h_w  in  3  width/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- din  in  32  write/fill data
- hit  out  1  registered hit of the last load/edit
- hit_way  out  log2(WAYS)  way that hit
- dout  out  32  load data, or victim word during evict
- valid, dirty  out  1 each  victim way flags, or hit way flags on a hit
- tag  out  TAG_BITS  tag of the same way as valid/dirty
- busy  out  1  high while FILL, EVICT or FLUSH is active

## Operation
- States are IDLE, FILL, EVICT and FLUSH.
- IDLE arbitration priority: invalid > store > evict > load/edit. load and edit are ignored when not in IDLE.
- Lookup: way w hits when valid[set][w] && tag[set][w]==addr tag. At most one way hits.
- Load hit: dout is the extracted data. Half-word is selected by addr[1]; byte by addr[1:0]. Unsigned loads zero-extend; signed loads sign-extend.
- Load miss: dout=0.
- Edit hit: merges din[7:0], din[15:0] or din into the byte, half or word lane, then sets dirty.
- Edit miss: changes nothing.
- LRU:
  - Each set holds one log2(WAYS)-bit age per way. The ages form a permutation of 0..WAYS-1.
  - On a load hit, edit hit, or completed fill of way w: every way with age < age[w] increments, then age[w]=0.
  - Victim selection: the lowest-index invalid way; otherwise the way with age==WAYS-1.
- FILL:
  - The victim way is latched on the first beat.
  - Beat k writes din into word k, counting 0..LINE_WORDS-1 and ignoring addr offset bits.
  - Addr index and tag are latched on the first beat.
  - A beat happens only on cycles with store=1; gaps stall the counter.
  - After the last beat: valid=1, dirty=0, tag written, LRU touched, return to IDLE.
- EVICT:
  - The victim is latched at entry.
  - On consecutive cycles dout presents victim words 0..LINE_WORDS-1. tag, valid and dirty show the victim for the whole burst.
  - EVICT does not change state or LRU. It returns to IDLE after the last word.
- FLUSH:
  - Sweeps set 0..SETS-1, one set per cycle.
  - Clears valid and dirty, and resets ages to age[w]=w.
  - Returns to IDLE after set SETS-1.
- Reset: the same clear as FLUSH, but completes in one cycle (the arrays reset in parallel). State returns to IDLE; the fill, evict and flush counters clear. Data words are not cleared.

## Timing
- Every output is registered.
- Output reset values: hit=0, hit_way=0, dout=0, valid=0, dirty=0, tag=0, busy=0.
- Load/edit latency is 1: inputs at edge n, hit, hit_way and dout visible after edge n+1.
- Edit data is readable by a load issued the next cycle.
- In IDLE, valid, dirty and tag reflect the victim way of addr's set (the hit way on a hit), 1 cycle later.
- busy rises the cycle after the starting request and falls the cycle after the final beat, word or set.
- Minimum durations: FILL is LINE_WORDS cycles, EVICT is LINE_WORDS cycles, FLUSH is SETS cycles.
- EVICT word k appears on dout k+1 cycles after the evict edge.
- load and edit together on the same hit: edit writes, and dout returns the pre-edit data.
- rst during FILL, EVICT or FLUSH aborts the operation. A partially filled line stays invalid.

## Test plan
Configuration: WAYS=4, SETS=16, LINE_WORDS=4. Index is addr[7:4].
- Reset, then LW at 0x1000 -> hit=0, dout=0, valid=0, busy=0.
- Fill 0x1000 with 0x11, 0x22, 0x80332211, 0x44, with one gap cycle -> busy held for 5 cycles. Then:
  - LW 0x1008 -> 0x80332211
  - LB 0x100B -> 0xFFFFFF80
  - LBU 0x100B -> 0x00000080
  - LHU 0x100A -> 0x00008033
- SH at 0x1002 with din=0xBEEF, then LW 0x1000 -> 0xBEEF0011, dirty=1.
- LRU in set 0:
  - Fill 0x000, 0x100, 0x200, 0x300, then LW 0x000.
  - Fill 0x400 -> replaces 0x100: LW 0x100 gives hit=0; LW 0x000 gives hit=1 with hit_way=0.
- Evict after the SH case -> dout over 4 cycles is 0xBEEF0011, 0x22, 0x80332211, 0x44, with dirty=1 and tag=0x000010.
- Flush -> busy for 16 cycles, then every prior address misses. Assert rst on beat 2 of a fill -> busy=0 next cycle, and that line misses.
